// File: rtl/mm_ctrl.sv
// Multi-cycle main-memory controller behind the data cache: fills, write-throughs and
// dirty-line swaps (write-back then fill), each array access taking LAT cycles.
module mm_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic              req_swap,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_old_tag,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_WR, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   old_tag_q, old_tag_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      old_tag_q <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      old_tag_q <= old_tag_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  // Array is never cleared; rst only suppresses a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= wdata_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    old_tag_d = old_tag_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && (req_rd || req_wr || req_swap)) begin
          addr_d    = req_addr;
          old_tag_d = req_old_tag;
          wdata_d   = req_wdata;
          cnt_d     = CNT_LOAD;
          if (req_swap)    state_d = S_WB;
          else if (req_wr) state_d = S_WR;
          else             state_d = S_RD;
        end
      end
      S_WB: begin
        if (cnt_q == '0) begin
          mem_we    = 1'b1;
          mem_waddr = old_tag_q;
          cnt_d     = CNT_LOAD;
          state_d   = S_RD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          rdata_d = mem[addr_q];
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR: begin
        if (cnt_q == '0) begin
          mem_we  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rdata_q;
  end

endmodule
